// File: rtl/cic_strobe_pkg.sv
// Shared definitions for the CIC decimation strobe monitor: FSM encoding and
// error-tally width.
package cic_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } mon_state_e;

    localparam int unsigned ERR_W = 8;

    // Saturating increment helper shared by error tallies.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        logic [ERR_W-1:0] result;
        if (value == {ERR_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a
// simultaneous increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-count selection: clear first, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {WIDTH{1'b0}};
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cic_strobe_monitor.sv
// Measures the spacing of a decimated strobe in input-rate pulses, locks when
// it repeatedly equals the programmed ratio, and tallies protocol errors.
module cic_strobe_monitor
    import cic_strobe_pkg::*;
#(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             strobe_fast,
    input  logic             strobe_slow,
    input  logic [WIDTH-1:0] expected_rate,
    input  logic             clear_err,
    output logic [WIDTH-1:0] measured_rate,
    output logic             rate_valid,
    output logic             locked,
    output logic [WIDTH-1:0] phase,
    output logic             rate_error,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [WIDTH-1:0] PHASE_MAX   = {WIDTH{1'b1}};
    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);

    logic [1:0]       rst_sync_q;
    logic             active_s;
    mon_state_e       state_q;
    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] measured_q;
    logic [3:0]       match_q;
    logic             rate_valid_q;
    logic             locked_q;
    logic             rate_error_q;
    logic [WIDTH:0]   interval_s;
    logic             interval_match_s;
    logic             legal_s;
    logic             orphan_s;
    logic             timeout_s;
    logic             err_event_s;

    // Reset release synchroniser; the FSM is held until two edges have passed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign active_s = rst_sync_q[1];

    // The interval is one wider than phase so a full-range gap never aliases
    // onto a small expected_rate.
    assign interval_s       = {1'b0, phase_q} + {{WIDTH{1'b0}}, 1'b1};
    assign interval_match_s = (expected_rate != {WIDTH{1'b0}}) &&
                              (interval_s == {1'b0, expected_rate});
    assign legal_s   = strobe_fast & strobe_slow;
    assign orphan_s  = strobe_slow & ~strobe_fast;
    assign timeout_s = strobe_fast & ~strobe_slow & (phase_q == PHASE_MAX);

    // Single error source feeding both the pulse and the tally.
    always_comb begin
        err_event_s = 1'b0;
        if (!active_s || !enable) begin
            err_event_s = 1'b0;
        end else if (orphan_s) begin
            err_event_s = 1'b1;
        end else if (state_q == ST_IDLE) begin
            err_event_s = 1'b0;
        end else if (timeout_s) begin
            err_event_s = 1'b1;
        end else if (legal_s && (state_q == ST_LOCKED) && !interval_match_s) begin
            err_event_s = 1'b1;
        end else begin
            err_event_s = 1'b0;
        end
    end

    // Monitor FSM with registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= {WIDTH{1'b0}};
            measured_q   <= {WIDTH{1'b0}};
            match_q      <= 4'd0;
            rate_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            rate_error_q <= 1'b0;
        end else begin
            rate_error_q <= err_event_s;
            if (!active_s) begin
                state_q <= ST_IDLE;
            end else if (!enable) begin
                state_q      <= ST_IDLE;
                phase_q      <= {WIDTH{1'b0}};
                match_q      <= 4'd0;
                rate_valid_q <= 1'b0;
                locked_q     <= 1'b0;
            end else if (orphan_s) begin
                state_q <= state_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SEARCH;
                    end
                    ST_SEARCH, ST_TRACK, ST_LOCKED: begin
                        if (timeout_s) begin
                            state_q      <= ST_SEARCH;
                            phase_q      <= {WIDTH{1'b0}};
                            match_q      <= 4'd0;
                            rate_valid_q <= 1'b0;
                            locked_q     <= 1'b0;
                        end else if (legal_s) begin
                            phase_q <= {WIDTH{1'b0}};
                            if (state_q == ST_SEARCH) begin
                                // The gap before the first event is partial.
                                state_q <= ST_TRACK;
                            end else begin
                                measured_q   <= interval_s[WIDTH-1:0];
                                rate_valid_q <= 1'b1;
                                if (!interval_match_s) begin
                                    match_q  <= 4'd0;
                                    locked_q <= 1'b0;
                                    state_q  <= ST_TRACK;
                                end else if (state_q == ST_LOCKED) begin
                                    state_q <= ST_LOCKED;
                                end else if ((match_q + 4'd1) == LOCK_TARGET) begin
                                    match_q  <= 4'd0;
                                    locked_q <= 1'b1;
                                    state_q  <= ST_LOCKED;
                                end else begin
                                    match_q <= match_q + 4'd1;
                                end
                            end
                        end else if (strobe_fast) begin
                            phase_q <= phase_q + {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            phase_q <= phase_q;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_count (
        .clock   (clock),
        .reset_n (reset_n),
        .clear_i (clear_err),
        .inc_i   (err_event_s),
        .count_o (err_count)
    );

    assign measured_rate = measured_q;
    assign rate_valid    = rate_valid_q;
    assign locked        = locked_q;
    assign phase         = phase_q;
    assign rate_error    = rate_error_q;

endmodule

// File: tb/tb_cic_strobe_monitor.sv
// Bench for cic_strobe_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model.
module tb_cic_strobe_monitor;

    localparam int W    = 9;
    localparam int MAXP = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         strobe_fast;
    logic         strobe_slow;
    logic [W-1:0] expected_rate;
    logic         clear_err;
    logic [W-1:0] measured_rate;
    logic         rate_valid;
    logic         locked;
    logic [W-1:0] phase;
    logic         rate_error;
    logic [7:0]   err_count;

    int total = 0;
    int bad   = 0;

    // Model state: 0 idle, 1 search, 2 track, 3 locked.
    int m_state, m_phase, m_match, m_meas, m_rv, m_lock, m_rerr, m_err, m_rst_cnt;

    cic_strobe_monitor #(.WIDTH(W), .LOCK_COUNT(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .strobe_fast   (strobe_fast),
        .strobe_slow   (strobe_slow),
        .expected_rate (expected_rate),
        .clear_err     (clear_err),
        .measured_rate (measured_rate),
        .rate_valid    (rate_valid),
        .locked        (locked),
        .phase         (phase),
        .rate_error    (rate_error),
        .err_count     (err_count)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_match = 0; m_meas = 0;
        m_rv = 0; m_lock = 0; m_rerr = 0; m_err = 0; m_rst_cnt = 0;
    endtask

    task automatic model_step(input int f, input int s, input int en, input int exp_r, input int clr);
        int err;
        int interval;
        err = 0;
        if (m_rst_cnt < 2) begin
            m_rst_cnt++;
        end else if (en == 0) begin
            m_state = 0; m_phase = 0; m_match = 0; m_rv = 0; m_lock = 0;
        end else if (s == 1 && f == 0) begin
            err = 1;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (f == 1 && s == 0 && m_phase == MAXP) begin
            err = 1; m_rv = 0; m_lock = 0; m_phase = 0; m_match = 0; m_state = 1;
        end else if (f == 1 && s == 1) begin
            interval = m_phase + 1;
            m_phase = 0;
            if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_meas = interval % (MAXP + 1);
                m_rv = 1;
                if (interval != exp_r) begin
                    m_match = 0;
                    if (m_state == 3) begin
                        err = 1; m_lock = 0; m_state = 2;
                    end
                end else if (m_state == 2) begin
                    m_match++;
                    if (m_match == 4) begin
                        m_state = 3; m_lock = 1; m_match = 0;
                    end
                end
            end
        end else if (f == 1) begin
            m_phase++;
        end
        m_rerr = err;
        if (clr != 0) m_err = 0;
        else if (err != 0 && m_err < 255) m_err++;
    endtask

    task automatic check_all(input string tag);
        chk_eq({tag, ".measured_rate"}, 32'(measured_rate), m_meas);
        chk_eq({tag, ".rate_valid"},    32'(rate_valid),    m_rv);
        chk_eq({tag, ".locked"},        32'(locked),        m_lock);
        chk_eq({tag, ".phase"},         32'(phase),         m_phase);
        chk_eq({tag, ".rate_error"},    32'(rate_error),    m_rerr);
        chk_eq({tag, ".err_count"},     32'(err_count),     m_err);
    endtask

    // One clock: drive, step the model on the edge, compare just after it.
    task automatic cyc(input logic f, input logic s, input string tag);
        strobe_fast = f;
        strobe_slow = s;
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step(int'(f), int'(s), int'(enable), int'(expected_rate), int'(clear_err));
        #1;
        check_all(tag);
    endtask

    initial begin
        int period;
        int fcnt;
        logic f;
        logic s;
        reset_n = 1'b0; enable = 1'b0; strobe_fast = 1'b0; strobe_slow = 1'b0;
        expected_rate = 9'd320; clear_err = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        cyc(1'b1, 1'b1, "in_reset");
        cyc(1'b1, 1'b1, "in_reset");
        reset_n = 1'b1;
        enable  = 1'b1;

        // Lock at 320.
        for (int i = 0; i < 1600; i++) cyc(1'b1, (i % 320) == 319, "lock");
        chk_eq("lock_locked", 32'(locked), 32'd1);
        chk_eq("lock_rate", 32'(measured_rate), 32'd320);
        chk_eq("lock_err", 32'(err_count), 32'd0);

        // A single short interval while locked.
        for (int j = 0; j < 319; j++) cyc(1'b1, j == 318, "mismatch");
        chk_eq("mis_pulse", 32'(rate_error), 32'd1);
        chk_eq("mis_err", 32'(err_count), 32'd1);
        chk_eq("mis_locked", 32'(locked), 32'd0);
        chk_eq("mis_rate", 32'(measured_rate), 32'd319);
        cyc(1'b1, 1'b0, "mis_after");
        for (int n = 2; n <= 1280; n++) cyc(1'b1, (n % 320) == 0, "relock");
        chk_eq("relock_locked", 32'(locked), 32'd1);

        // Timeout after 512 fast pulses with no slow strobe.
        for (int k = 0; k < 512; k++) cyc(1'b1, 1'b0, "timeout");
        chk_eq("to_pulse", 32'(rate_error), 32'd1);
        chk_eq("to_valid", 32'(rate_valid), 32'd0);
        chk_eq("to_phase", 32'(phase), 32'd0);
        chk_eq("to_err", 32'(err_count), 32'd2);

        // Orphan, then clear coincident with a second orphan.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, "pre_orphan");
        cyc(1'b0, 1'b1, "orphan");
        chk_eq("orphan_err", 32'(err_count), 32'd3);
        chk_eq("orphan_phase", 32'(phase), 32'd5);
        clear_err = 1'b1;
        cyc(1'b0, 1'b1, "orphan_clr");
        clear_err = 1'b0;
        chk_eq("clr_err", 32'(err_count), 32'd0);

        // Ratio 1: slow accompanies every fast.
        expected_rate = 9'd1;
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, "rate1");
        chk_eq("rate1_locked", 32'(locked), 32'd1);
        cyc(1'b0, 1'b1, "rate1_orphan");

        // Enable drop while locked keeps the tally.
        enable = 1'b0;
        cyc(1'b1, 1'b1, "disable");
        chk_eq("dis_locked", 32'(locked), 32'd0);
        chk_eq("dis_err", 32'(err_count), 32'd1);

        // Asynchronous reset mid-interval.
        enable = 1'b1;
        expected_rate = 9'd320;
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, "pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk_eq("async_rst_phase", 32'(phase), 32'd0);
        cyc(1'b1, 1'b0, "rst_hold");
        reset_n = 1'b1;

        // Randomized traffic around small ratios.
        period = 3;
        fcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 4))
                    0: expected_rate = 9'd0;
                    1: expected_rate = 9'd1;
                    2: expected_rate = 9'd2;
                    default: expected_rate = 9'($urandom_range(3, 8));
                endcase
                period = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                      : ((expected_rate == 9'd0) ? 4 : int'(expected_rate));
            end
            f = ($urandom_range(0, 3) != 0);
            s = 1'b0;
            if (f) begin
                fcnt++;
                if (fcnt >= period) begin
                    s = 1'b1;
                    fcnt = 0;
                end
            end
            if ($urandom_range(0, 49) == 0) s = ~s;
            enable    = ($urandom_range(0, 299) != 0);
            clear_err = ($urandom_range(0, 99) == 0);
            cyc(f, s, "rand");
        end
        clear_err = 1'b0;
        enable = 1'b1;

        // Saturation.
        for (int k = 0; k < 260; k++) cyc(1'b0, 1'b1, "saturate");
        chk_eq("sat_err", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_strobe_monitor.md
CIC_STROBE_MONITOR -- requirements
Module: cic_strobe_monitor

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 9, width of rate, interval and phase fields.
  LOCK_COUNT, 4, number of consecutive matching intervals needed to lock (range 1..15).
REQ-002 Ports SHALL be, one per line:
  clock  in  1  single clock domain.
  reset_n  in  1  reset, asynchronous, active-low.
  enable  in  1  monitor enable; low forces IDLE.
  strobe_fast  in  1  input-rate sample strobe.
  strobe_slow  in  1  decimated strobe under test.
  expected_rate  in  WIDTH  programmed divide ratio.
  clear_err  in  1  synchronous clear of err_count.
  measured_rate  out  WIDTH  last complete interval, counted in strobe_fast pulses.
  rate_valid  out  1  measured_rate holds a complete interval.
  locked  out  1  LOCK_COUNT consecutive intervals equal expected_rate.
  phase  out  WIDTH  strobe_fast pulses since the last legal strobe_slow.
  rate_error  out  1  one-cycle error pulse.
  err_count  out  8  saturating error tally.

Function
REQ-003 A legal slow event SHALL be strobe_slow=1 with strobe_fast=1 in the same cycle; interval = phase+1, and phase SHALL clear to 0 on that cycle.
REQ-004 On each strobe_fast=1 cycle without strobe_slow, phase SHALL increment by 1; phase SHALL hold on cycles with strobe_fast=0.
REQ-005 Orphan event (strobe_slow=1, strobe_fast=0, enable=1): pulse rate_error and increment err_count; state, phase and measured_rate SHALL stay unchanged.
REQ-006 The FSM SHALL have four states: IDLE, SEARCH, TRACK, LOCKED.
REQ-007 IDLE: phase=0, match count=0, rate_valid=0, locked=0; go to SEARCH on the first cycle with enable=1.
REQ-008 SEARCH: the first legal slow event SHALL go to TRACK without measuring, because the interval before it is partial.
REQ-009 TRACK: each legal slow event SHALL load measured_rate=interval and set rate_valid=1.
  - interval==expected_rate: match count increments.
  - otherwise: match count clears.
  - match count reaching LOCK_COUNT: go to LOCKED.
REQ-010 LOCKED, legal slow event with interval!=expected_rate:
  - update measured_rate;
  - pulse rate_error and increment err_count;
  - go to TRACK with match count=0;
  - drop locked.
REQ-011 Timeout: in SEARCH, TRACK or LOCKED, a strobe_fast without strobe_slow while phase==2^WIDTH-1 SHALL:
  - pulse rate_error and increment err_count;
  - set rate_valid=0 and locked=0;
  - set phase=0;
  - go to SEARCH.
REQ-012 All outputs SHALL be registered; the effect of an event SHALL appear on outputs exactly one cycle after the event cycle.
REQ-013 enable=0 in any state SHALL force IDLE on the next edge, mid-interval included; err_count SHALL be retained.
REQ-014 err_count SHALL saturate at 255; clear_err=1 SHALL set it to 0 and SHALL take priority over a simultaneous increment.
REQ-015 rate_error SHALL pulse at most once per cycle, even if an orphan and a timeout coincide; err_count then increments by exactly 1.
REQ-016 expected_rate==0 SHALL never match, so locked stays 0.
REQ-017 expected_rate==1 SHALL lock when strobe_slow accompanies every strobe_fast.
REQ-018 A change of expected_rate SHALL take effect at the next comparison without resetting state.

Reset
REQ-019 reset_n=0 SHALL asynchronously force: state=IDLE, phase=0, measured_rate=0, rate_valid=0, locked=0, rate_error=0, err_count=0, match count=0.
REQ-020 Release of reset SHALL be synchronised internally; the first state change SHALL occur no earlier than the second clock edge after deassertion.

Structure
REQ-021 The state encoding and the err_count width SHALL live in shared package cic_strobe_pkg.
REQ-022 The saturating err_count with clear priority SHALL be sub-module sat_counter (parameter width 8).

Verification
REQ-023 Lock: WIDTH=9, expected_rate=320, strobe_fast every cycle, legal strobe_slow every 320th -> locked=1 one cycle after the 5th slow event (1 discarded + 4 matches), measured_rate=320, err_count=0.
REQ-024 Mismatch: while locked, one interval of 319 -> rate_error one cycle, err_count=1, locked=0, measured_rate=319; relock after 4 further intervals of 320.
REQ-025 Timeout: while locked, stop strobe_slow -> after 512 strobe_fast pulses, rate_error pulses, state SEARCH, rate_valid=0, phase=0.
REQ-026 Orphan plus clear: strobe_slow with strobe_fast=0 -> err_count increments and phase unchanged; then clear_err coincident with a second orphan -> err_count=0.
REQ-027 Reset and enable: assert reset_n mid-interval -> all outputs 0 immediately, without waiting for a clock edge; drop enable while locked -> locked=0 next cycle and err_count retained; 260 errors -> err_count=255.
